matrix_scan_ctrl: RTL and testbench
===================================

MATRIX_SCAN_CTRL -- requirements
Module: matrix_scan_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 1350: shift-clock half-period in clk cycles, at least 1.
REQ-002 SHALL have parameter DWELL, default 8192: display time per (row, color) slot in clk cycles, at least 1.
REQ-003 clk  in  1  single clock; all logic on posedge clk.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 wr_en  in  1  host write strobe into the back buffer.
REQ-006 wr_color  in  1  0=red plane, 1=green plane.
REQ-007 wr_row  in  3  target row.
REQ-008 wr_data  in  8  row pixels; bit7 is shifted first.
REQ-009 wr_ready  out  1  write accepted when wr_en && wr_ready.
REQ-010 swap_req  in  1  level request to swap front/back buffers.
REQ-011 swap_ack  out  1  one-cycle pulse when the swap is performed.
REQ-012 ser_data  out  1  serial pixel data to the shift register.
REQ-013 sh_clk  out  1  shift-register clock.
REQ-014 st_clk  out  1  storage-register latch clock.
REQ-015 row_sel  out  3  active row index.
REQ-016 col_red_n, col_green_n  out  1 each  active-low color enables.
REQ-017 frame_start  out  1  one-cycle pulse at the start of each frame.

Function
REQ-018 SHALL keep two frame buffers (front, back); each is 2 colors x 8 rows x 8 bits. Scan reads only front; writes go only to back.
REQ-019 Slot order per frame SHALL be (row0,red), (row0,green), (row1,red) ... (row7,green): 16 slots, wrapping row 7 to row 0.
REQ-020 FSM states SHALL be SHIFT, LATCH, DISPLAY; reset enters SHIFT at slot (row0,red).
REQ-021 SHIFT: for bit i=7..0, drive ser_data=front[color][row][i] with sh_clk low for CLK_DIV cycles, then sh_clk high for CLK_DIV cycles; ser_data is stable while sh_clk is high; 16*CLK_DIV cycles total.
REQ-022 LATCH: sh_clk low, st_clk high for CLK_DIV cycles, then st_clk low on entry to DISPLAY.
REQ-023 col_red_n and col_green_n SHALL both be 1 in SHIFT and LATCH (blanking).
REQ-024 DISPLAY: for DWELL cycles, the selected color's enable is 0 and the other is 1; row_sel equals the slot row.
REQ-025 row_sel SHALL update on entry to SHIFT of a new row and stay constant for that row's two slots.
REQ-026 Slot length SHALL be exactly 17*CLK_DIV+DWELL cycles, with no idle cycles between states.
REQ-027 frame_start SHALL pulse in the first cycle of slot (row0,red) of every frame, including the first after reset.
REQ-028 swap_req is sampled in the last DISPLAY cycle of (row7,green). If it is 1, front/back are exchanged so the next frame uses the new front, and swap_ack pulses in the first cycle of the next frame.
REQ-029 wr_ready SHALL be 0 in the swap cycle and 1 in all other cycles after reset. A write coinciding with the swap is not accepted and is held off by the host.
REQ-030 A write to back while front is being scanned SHALL never alter the displayed data.
REQ-031 Repeated writes to the same address: the last accepted write wins.
REQ-032 swap_req held high across frames SHALL swap once per frame boundary.

Reset
REQ-033 While rst_n=0: ser_data=0, sh_clk=0, st_clk=0, row_sel=0, col_red_n=1, col_green_n=1, swap_ack=0, frame_start=0, wr_ready=0.
REQ-034 Reset SHALL clear both buffers to 0 and set the buffer-select bit to 0; counters reset to 0.
REQ-035 Reset asserted mid-slot SHALL abort immediately, with outputs at reset values on the next clk; after release, the scan restarts at (row0,red) with a frame_start pulse.

Verification (CLK_DIV=2, DWELL=4; slot=38 cycles, frame=608 cycles)
REQ-036 Write back red row0=0xA5, then swap_req=1 -> swap_ack at frame boundary; in the next frame, ser_data at the 8 sh_clk rises = 1,0,1,0,0,1,0,1; st_clk high 2 cycles; col_red_n=0 for 4 cycles.
REQ-037 Free-run after reset -> frame_start every 608 cycles; row_sel steps 0..7 every 76 cycles; enables never both 0; enables are 1 whenever sh_clk or st_clk toggles.
REQ-038 Write back green row3=0xFF without a swap -> displayed data unchanged (all 0s shifted) for two frames.
REQ-039 wr_en held high across a frame boundary with swap_req=1 -> wr_ready=0 exactly in the swap cycle; the stalled write lands in the new back buffer after it.
REQ-040 rst_n low for 1 cycle mid-SHIFT of (row5,green) -> outputs at reset values the next cycle; buffers read 0; scan resumes at (row0,red) with frame_start.

Source files
------------

// File: rtl/matrix_scan_ctrl_if.sv
// Host-side port bundle of the matrix scan controller: back-buffer writes and
// the frame swap handshake.
interface matrix_scan_ctrl_if;
    logic       wr_en;
    logic       wr_color;
    logic [2:0] wr_row;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       swap_req;
    logic       swap_ack;

    modport master (
        output wr_en,
        output wr_color,
        output wr_row,
        output wr_data,
        output swap_req,
        input  wr_ready,
        input  swap_ack
    );

    modport slave (
        input  wr_en,
        input  wr_color,
        input  wr_row,
        input  wr_data,
        input  swap_req,
        output wr_ready,
        output swap_ack
    );
endinterface

// File: rtl/matrix_scan_ctrl.sv
// Double-buffered 8x8 bicolor LED matrix scanner: shifts each (row, color) slot
// out serially, latches it, then lights it for a fixed dwell time.
module matrix_scan_ctrl #(
    parameter int CLK_DIV = 1350,
    parameter int DWELL   = 8192
) (
    input  logic                clk,
    input  logic                rst_n,
    matrix_scan_ctrl_if.slave   host,
    output logic                ser_data,
    output logic                sh_clk,
    output logic                st_clk,
    output logic [2:0]          row_sel,
    output logic                col_red_n,
    output logic                col_green_n,
    output logic                frame_start
);

    localparam int CNT_MAX = (CLK_DIV > DWELL) ? CLK_DIV : DWELL;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

    typedef enum logic [1:0] {SHIFT, LATCH, DISPLAY} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [3:0]       half, half_nx;
    logic [3:0]       slot, slot_nx;
    logic             started;
    logic             buf_sel, buf_sel_nx;
    logic             frame_end;
    logic             swap_now;
    logic             wr_fire;
    logic [7:0]       row_bits;
    logic [2:0]       bit_idx;

    // fb[buffer][{row, color}]; buf_sel names the front buffer
    logic [7:0] fb [2][16];

    // Position of the next cycle; slot = {row, color}, half = sh_clk half-period index
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt + 1'b1;
        half_nx   = half;
        slot_nx   = slot;
        frame_end = 1'b0;
        if (!started) begin
            state_nx = SHIFT;
            cnt_nx   = '0;
            half_nx  = '0;
            slot_nx  = '0;
        end else begin
            case (state)
                SHIFT: begin
                    if (cnt == DIV_LAST) begin
                        cnt_nx = '0;
                        if (half == 4'd15) state_nx = LATCH;
                        else               half_nx  = half + 1'b1;
                    end
                end
                LATCH: begin
                    if (cnt == DIV_LAST) begin
                        cnt_nx   = '0;
                        state_nx = DISPLAY;
                    end
                end
                DISPLAY: begin
                    if (cnt == DWELL_LAST) begin
                        cnt_nx    = '0;
                        state_nx  = SHIFT;
                        half_nx   = '0;
                        slot_nx   = slot + 1'b1;
                        frame_end = (slot == 4'd15);
                    end
                end
                default: begin
                    state_nx = SHIFT;
                    cnt_nx   = '0;
                    half_nx  = '0;
                    slot_nx  = '0;
                end
            endcase
        end

        swap_now   = frame_end & host.swap_req;
        buf_sel_nx = buf_sel ^ swap_now;
        wr_fire    = host.wr_en & host.wr_ready;
        bit_idx    = 3'd7 - half_nx[3:1];

        // A write landing on the swap edge goes into what becomes the front buffer
        row_bits = fb[buf_sel_nx][slot_nx];
        if (wr_fire && ((~buf_sel) == buf_sel_nx) && ({host.wr_row, host.wr_color} == slot_nx))
            row_bits = host.wr_data;
    end

    // Scan FSM, frame buffers and all outputs registered for the upcoming cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= SHIFT;
            cnt           <= '0;
            half          <= '0;
            slot          <= '0;
            started       <= 1'b0;
            buf_sel       <= 1'b0;
            for (int b = 0; b < 2; b++)
                for (int a = 0; a < 16; a++)
                    fb[b][a] <= '0;
            ser_data      <= 1'b0;
            sh_clk        <= 1'b0;
            st_clk        <= 1'b0;
            row_sel       <= '0;
            col_red_n     <= 1'b1;
            col_green_n   <= 1'b1;
            frame_start   <= 1'b0;
            host.swap_ack <= 1'b0;
            host.wr_ready <= 1'b0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            half          <= half_nx;
            slot          <= slot_nx;
            started       <= 1'b1;
            buf_sel       <= buf_sel_nx;
            if (wr_fire)
                fb[~buf_sel][{host.wr_row, host.wr_color}] <= host.wr_data;
            ser_data      <= (state_nx == SHIFT) ? row_bits[bit_idx] : 1'b0;
            sh_clk        <= (state_nx == SHIFT) && half_nx[0];
            st_clk        <= (state_nx == LATCH);
            row_sel       <= slot_nx[3:1];
            col_red_n     <= !((state_nx == DISPLAY) && !slot_nx[0]);
            col_green_n   <= !((state_nx == DISPLAY) &&  slot_nx[0]);
            frame_start   <= !started || frame_end;
            host.swap_ack <= swap_now;
            host.wr_ready <= !swap_now;
        end
    end

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Self-checking bench for matrix_scan_ctrl: vector table of write/swap scenarios,
// hand sequences for swap stalls and mid-slot reset, and randomized host traffic.
module tb_matrix_scan_ctrl;

    localparam int CLK_DIV = 2;
    localparam int DWELL   = 4;
    localparam int SLOT    = 17 * CLK_DIV + DWELL;
    localparam int FRAME   = 16 * SLOT;

    logic       clk;
    logic       rst_n;
    logic       ser_data;
    logic       sh_clk;
    logic       st_clk;
    logic [2:0] row_sel;
    logic       col_red_n;
    logic       col_green_n;
    logic       frame_start;

    matrix_scan_ctrl_if bus();

    matrix_scan_ctrl #(.CLK_DIV(CLK_DIV), .DWELL(DWELL)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .host        (bus),
        .ser_data    (ser_data),
        .sh_clk      (sh_clk),
        .st_clk      (st_clk),
        .row_sel     (row_sel),
        .col_red_n   (col_red_n),
        .col_green_n (col_green_n),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: cycle index since frame start (-1 = reset/pre-start) and
    // the two buffers as plain arrays indexed [color][row].
    int         t;
    bit         m_swapped;
    logic [7:0] m_front [2][8];
    logic [7:0] m_back  [2][8];

    typedef struct {
        logic       color;
        logic [2:0] row;
        logic [7:0] data;
        logic       swap;
        logic       cap_color;
        logic [2:0] cap_row;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [7];

    task automatic model_clear();
        for (int c = 0; c < 2; c++)
            for (int r = 0; r < 8; r++) begin
                m_front[c][r] = '0;
                m_back[c][r]  = '0;
            end
        m_swapped = 1'b0;
        t = -1;
    endtask

    function automatic bit exp_wr_ready(input int tc);
        return (tc >= 0) && !((tc % FRAME == 0) && m_swapped);
    endfunction

    task automatic checkOutput();
        logic [9:0] exp_v, act_v;
        logic       exp_ser;
        bit         chk_ser;
        int         off, s, row, color;
        bit         e_sh, e_st, disp, fs;
        if (t < 0) begin
            exp_v   = 10'b00_000_11_000;
            chk_ser = 1'b1;
            exp_ser = 1'b0;
        end else begin
            off   = t % SLOT;
            s     = (t / SLOT) % 16;
            row   = s / 2;
            color = s % 2;
            e_sh  = (off < 16 * CLK_DIV) && ((off % (2 * CLK_DIV)) >= CLK_DIV);
            e_st  = (off >= 16 * CLK_DIV) && (off < 17 * CLK_DIV);
            disp  = (off >= 17 * CLK_DIV);
            fs    = (t % FRAME == 0);
            exp_v = {e_sh, e_st, 3'(row), !(disp && color == 0), !(disp && color == 1),
                     fs, fs && m_swapped, exp_wr_ready(t)};
            chk_ser = e_sh;
            exp_ser = e_sh ? m_front[color][row][7 - off / (2 * CLK_DIV)] : 1'b0;
        end
        act_v = {sh_clk, st_clk, row_sel, col_red_n, col_green_n, frame_start,
                 bus.swap_ack, bus.wr_ready};
        n_checks++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL outputs t=%0d {sh,st,row,rn,gn,fs,ack,rdy} got %b expected %b",
                     t, act_v, exp_v);
        end
        if (chk_ser) begin
            n_checks++;
            if (ser_data !== exp_ser) begin
                n_fail++;
                $display("[TB] FAIL ser_data t=%0d got %b expected %b", t, ser_data, exp_ser);
            end
        end
    endtask

    // Ends the current cycle with the inputs now driven, advances the model, checks.
    task automatic applyStimulus();
        logic [7:0] tmp;
        bit wr_ok, do_swap;
        if (!rst_n) begin
            @(posedge clk);
            #1;
            model_clear();
        end else begin
            wr_ok   = bus.wr_en && exp_wr_ready(t);
            do_swap = (t >= 0) && (t % FRAME == FRAME - 1) && bus.swap_req;
            if (wr_ok) m_back[bus.wr_color][bus.wr_row] = bus.wr_data;
            if (do_swap)
                for (int c = 0; c < 2; c++)
                    for (int r = 0; r < 8; r++) begin
                        tmp           = m_front[c][r];
                        m_front[c][r] = m_back[c][r];
                        m_back[c][r]  = tmp;
                    end
            m_swapped = do_swap;
            t++;
            @(posedge clk);
            #1;
        end
        checkOutput();
    endtask

    task automatic run_to(input int target);
        int guard = 0;
        while (t < target && guard < 20000) begin
            applyStimulus();
            guard++;
        end
    endtask

    function automatic int next_frame();
        return t - (t % FRAME) + FRAME;
    endfunction

    task automatic host_write(input logic color, input logic [2:0] row, input logic [7:0] data);
        bus.wr_en    = 1'b1;
        bus.wr_color = color;
        bus.wr_row   = row;
        bus.wr_data  = data;
        applyStimulus();
        bus.wr_en    = 1'b0;
    endtask

    // Collects the 8 bits presented at the sh_clk rises of one slot of frame tf
    task automatic capture_row(input int tf, input logic color, input logic [2:0] row,
                               output logic [7:0] got);
        int s;
        s = int'(row) * 2 + int'(color);
        got = '0;
        for (int i = 7; i >= 0; i--) begin
            run_to(tf + s * SLOT + (7 - i) * 2 * CLK_DIV + CLK_DIV);
            got[i] = ser_data;
        end
    endtask

    task automatic check_byte(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s got %b expected %b", name, got, exp);
        end
    endtask

    initial begin
        logic [7:0] got;
        int tf;

        vecs[0] = '{1'b1, 3'd3, 8'hFF, 1'b0, 1'b1, 3'd3, 8'h00};
        vecs[1] = '{1'b0, 3'd0, 8'hA5, 1'b1, 1'b0, 3'd0, 8'hA5};
        vecs[2] = '{1'b0, 3'd0, 8'h3C, 1'b0, 1'b0, 3'd0, 8'hA5};
        vecs[3] = '{1'b0, 3'd0, 8'hC3, 1'b1, 1'b0, 3'd0, 8'hC3};
        vecs[4] = '{1'b1, 3'd3, 8'h81, 1'b1, 1'b1, 3'd3, 8'h81};
        vecs[5] = '{1'b1, 3'd5, 8'h5A, 1'b1, 1'b0, 3'd0, 8'hC3};
        vecs[6] = '{1'b0, 3'd7, 8'h01, 1'b0, 1'b1, 3'd5, 8'h5A};

        bus.wr_en    = 1'b0;
        bus.wr_color = 1'b0;
        bus.wr_row   = '0;
        bus.wr_data  = '0;
        bus.swap_req = 1'b0;
        rst_n        = 1'b0;
        model_clear();

        $display("[TB] reset and first frame start");
        for (int i = 0; i < 3; i++) applyStimulus();
        rst_n = 1'b1;
        applyStimulus();
        applyStimulus();
        check_bit("frame_start_after_first", frame_start, 1'b0);

        $display("[TB] write/swap vector table");
        for (int v = 0; v < 7; v++) begin
            host_write(vecs[v].color, vecs[v].row, vecs[v].data);
            bus.swap_req = vecs[v].swap;
            tf = next_frame();
            run_to(tf);
            bus.swap_req = 1'b0;
            check_bit($sformatf("swap_ack_vec%0d", v), bus.swap_ack, vecs[v].swap);
            capture_row(tf, vecs[v].cap_color, vecs[v].cap_row, got);
            check_byte($sformatf("shifted_byte_vec%0d", v), got, vecs[v].exp);
        end

        $display("[TB] write held across a swap boundary");
        tf = next_frame();
        bus.swap_req = 1'b1;
        run_to(tf - 1);
        host_write(1'b0, 3'd1, 8'h11);
        bus.swap_req = 1'b0;
        bus.wr_en    = 1'b1;
        bus.wr_data  = 8'h22;
        check_bit("wr_ready_in_swap_cycle", bus.wr_ready, 1'b0);
        applyStimulus();
        check_bit("wr_ready_after_swap", bus.wr_ready, 1'b1);
        applyStimulus();
        bus.wr_en = 1'b0;
        capture_row(tf, 1'b0, 3'd1, got);
        check_byte("pre_swap_write_in_front", got, 8'h11);
        tf = next_frame();
        bus.swap_req = 1'b1;
        run_to(tf);
        bus.swap_req = 1'b0;
        capture_row(tf, 1'b0, 3'd1, got);
        check_byte("stalled_write_in_back", got, 8'h22);

        $display("[TB] randomized host traffic");
        bus.swap_req = 1'b1;
        tf = next_frame() + 3 * FRAME;
        while (t < tf) begin
            bus.wr_en    = ($urandom_range(0, 3) == 0);
            bus.wr_color = 1'($urandom_range(0, 1));
            bus.wr_row   = 3'($urandom_range(0, 7));
            bus.wr_data  = 8'($urandom);
            applyStimulus();
        end
        tf = t + 3 * FRAME;
        while (t < tf) begin
            if (t % FRAME == FRAME / 2) bus.swap_req = 1'($urandom_range(0, 1));
            bus.wr_en    = ($urandom_range(0, 2) == 0);
            bus.wr_color = 1'($urandom_range(0, 1));
            bus.wr_row   = 3'($urandom_range(0, 7));
            bus.wr_data  = 8'($urandom);
            applyStimulus();
        end
        bus.wr_en    = 1'b0;
        bus.swap_req = 1'b0;

        $display("[TB] reset pulse mid-shift of (row5, green)");
        host_write(1'b0, 3'd0, 8'hFF);
        bus.swap_req = 1'b1;
        run_to(next_frame());
        bus.swap_req = 1'b0;
        run_to(t - (t % FRAME) + 11 * SLOT + 3 * CLK_DIV);
        rst_n = 1'b0;
        applyStimulus();
        check_bit("sh_clk_in_reset", sh_clk, 1'b0);
        rst_n = 1'b1;
        applyStimulus();
        check_bit("frame_start_after_reset", frame_start, 1'b1);
        capture_row(0, 1'b0, 3'd0, got);
        check_byte("cleared_red_row0", got, 8'h00);
        capture_row(0, 1'b1, 3'd3, got);
        check_byte("cleared_green_row3", got, 8'h00);
        run_to(FRAME);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
